gram_update_sched: RTL

//  Write scheduler for the 1024x4 tile-map GRAM read by the HDMI tile renderer.
//  - Queues tile writes from the CPU bus.
//  - Commits them to the GRAM write port only during vertical blanking, so no frame tears.
//  - Adds a hardware clear-screen fill that takes priority over queued writes.
//  - Sits between the CPU peripheral bus and the GRAM write port; runs on the pixel clock.

---
 rtl/gram_pkg.sv | 15 +
 rtl/gram_wr_fifo.sv | 61 ++++++
 rtl/gram_update_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/gram_pkg.sv
// Shared defaults and FSM state encoding for the tile-map GRAM write scheduler.
package gram_pkg;

    localparam int GRAM_ADDR_W     = 10;
    localparam int GRAM_DATA_W     = 4;
    localparam int GRAM_TILE_CNT   = 1024;
    localparam int GRAM_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/gram_wr_fifo.sv
// Synchronous FIFO of packed {addr,data} tile writes with full/empty flags and fill count.
module gram_wr_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_s;
    logic             pop_s;

    assign full     = (count_r == (PTR_W+1)'(DEPTH));
    assign empty    = (count_r == '0);
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];
    assign push_s   = push && !full;
    assign pop_s    = pop && !empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/gram_update_sched.sv
// Queues CPU tile writes and commits them (plus a priority clear-screen fill) to the GRAM
// during vblank. Define GRAM_ANYTIME_WR_EN to remove the vblank gate for bring-up.
module gram_update_sched
    import gram_pkg::*;
#(
    parameter int ADDR_W     = GRAM_ADDR_W,
    parameter int DATA_W     = GRAM_DATA_W,
    parameter int TILE_CNT   = GRAM_TILE_CNT,
    parameter int FIFO_DEPTH = GRAM_FIFO_DEPTH
) (
    input  logic                          pix_clk,
    input  logic                          rst,
    input  logic                          vblank,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_data,
    input  logic                          clr_req,
    input  logic [DATA_W-1:0]             clr_data,
    output logic                          clr_busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          gram_we,
    output logic [ADDR_W-1:0]             gram_waddr,
    output logic [DATA_W-1:0]             gram_wdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(TILE_CNT - 1);

    sched_state_t         state_r;
    logic                 req_ready_r;
    logic                 clr_busy_r;
    logic                 clr_done_r;
    logic [DATA_W-1:0]    clr_data_r;
    logic [ADDR_W-1:0]    clr_addr_r;
    logic                 gram_we_r;
    logic [ADDR_W-1:0]    gram_waddr_r;
    logic [DATA_W-1:0]    gram_wdata_r;

    logic                       gate_s;
    logic                       clr_pend_s;
    logic                       fifo_push_s;
    logic                       fifo_pop_s;
    logic [ADDR_W+DATA_W-1:0]   fifo_rdata_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic [CNT_W-1:0]           fifo_count_s;
    logic [CNT_W-1:0]           count_nxt_s;

`ifdef GRAM_ANYTIME_WR_EN
    assign gate_s = 1'b1;
`else
    assign gate_s = vblank;
`endif

    // clr_done_r marks the one cycle after the final fill write, when busy is still shown.
    assign clr_pend_s  = clr_busy_r && !clr_done_r;
    assign fifo_push_s = req_valid && req_ready_r;
    assign count_nxt_s = fifo_count_s + CNT_W'(fifo_push_s) - CNT_W'(fifo_pop_s);

    assign req_ready  = req_ready_r;
    assign clr_busy   = clr_busy_r;
    assign pending    = fifo_count_s;
    assign gram_we    = gram_we_r;
    assign gram_waddr = gram_waddr_r;
    assign gram_wdata = gram_wdata_r;

    gram_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (pix_clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data ({req_addr, req_data}),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_rdata_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Pop decision: one entry per cycle while draining, unless a clear needs the port.
    always_comb begin
        fifo_pop_s = 1'b0;
        if (state_r == ST_DRAIN && gate_s && !fifo_empty_s && !clr_pend_s) begin
            fifo_pop_s = 1'b1;
        end else begin
            fifo_pop_s = 1'b0;
        end
    end

    // Scheduler FSM, clear counter, ready flag and registered GRAM write port.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b0;
            clr_busy_r   <= 1'b0;
            clr_done_r   <= 1'b0;
            clr_data_r   <= '0;
            clr_addr_r   <= '0;
            gram_we_r    <= 1'b0;
            gram_waddr_r <= '0;
            gram_wdata_r <= '0;
        end else begin
            req_ready_r <= (count_nxt_s != CNT_W'(FIFO_DEPTH)) || fifo_full_s && fifo_pop_s;
            gram_we_r   <= 1'b0;

            if (clr_done_r) begin
                clr_busy_r <= 1'b0;
                clr_done_r <= 1'b0;
            end else if (clr_req && !clr_busy_r) begin
                clr_busy_r <= 1'b1;
                clr_data_r <= clr_data;
            end

            case (state_r)
                ST_IDLE: begin
                    if (gate_s && clr_pend_s) begin
                        state_r    <= ST_CLEAR;
                        clr_addr_r <= '0;
                    end else if (gate_s && !fifo_empty_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // Address is held across a vblank gap so the sweep resumes in place.
                    if (gate_s) begin
                        gram_we_r    <= 1'b1;
                        gram_waddr_r <= clr_addr_r;
                        gram_wdata_r <= clr_data_r;
                        if (clr_addr_r == CLR_LAST) begin
                            state_r    <= ST_IDLE;
                            clr_done_r <= 1'b1;
                        end else begin
                            clr_addr_r <= clr_addr_r + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_pop_s) begin
                        gram_we_r    <= 1'b1;
                        gram_waddr_r <= fifo_rdata_s[ADDR_W+DATA_W-1:DATA_W];
                        gram_wdata_r <= fifo_rdata_s[DATA_W-1:0];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
